// File: rtl/next_line_prefetcher.sv
// Sequential next-line prefetcher: on a demand-miss trigger, fetch line+1 into a one-line buffer.
// Latency: trigger -> mem_read 1 cycle; mem_resp -> prefetch_ready 1 cycle.
// Backpressure: one request in flight; triggers while busy are dropped (counted); buffer held until pf_ack.
module next_line_prefetcher #(
   parameter int s_offset = 5,
   parameter int cnt_w    = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                trigger,
   input  logic [31:0]         trigger_address,
   output logic                mem_read,
   output logic [31:0]         mem_address,
   input  logic                mem_resp,
   input  logic [255:0]        mem_rdata,
   output logic                prefetch_ready,
   output logic [31:0]         pf_cline_address,
   output logic [255:0]        prefetch_rdata,
   input  logic                pf_ack,
   output logic [cnt_w-1:0]    issued_count,
   output logic [cnt_w-1:0]    dropped_count
);

   localparam int idx_w = 32 - s_offset;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      FULL = 2'd2
   } state_t;

   state_t              state_q;
   state_t              state_d;

   logic [31:0]         pf_addr_q;
   logic [255:0]        buf_q;
   logic [cnt_w-1:0]    issued_q;
   logic [cnt_w-1:0]    dropped_q;

   // Decoded per-cycle actions produced by the next-state logic
   logic                load_addr;
   logic                capture;
   logic                issue_inc;
   logic                drop_inc;

   // Next-line address computation
   logic [idx_w-1:0]    line_idx;
   logic [idx_w-1:0]    line_inc;
   logic [31:0]         next_addr;
   logic                line_wrap;
   logic                unused_offset;

   // Line-index arithmetic; the last line of the address space has no successor
   always_comb begin
      line_idx      = trigger_address[31:s_offset];
      line_inc      = line_idx + {{(idx_w-1){1'b0}}, 1'b1};
      next_addr     = {line_inc, {s_offset{1'b0}}};
      line_wrap     = &line_idx;
      unused_offset = ^trigger_address[s_offset-1:0];
   end

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and per-cycle action decode
   always_comb begin
      state_d   = state_q;
      load_addr = 1'b0;
      capture   = 1'b0;
      issue_inc = 1'b0;
      drop_inc  = 1'b0;
      case (state_q)
         IDLE: begin
            if (trigger) begin
               if (line_wrap) begin
                  drop_inc = 1'b1;
               end else begin
                  load_addr = 1'b1;
                  state_d   = REQ;
               end
            end
         end
         REQ: begin
            if (mem_resp) begin
               capture   = 1'b1;
               issue_inc = 1'b1;
               state_d   = FULL;
            end
            // Only one request may be outstanding; any new miss is lost
            if (trigger) begin
               drop_inc = 1'b1;
            end
         end
         FULL: begin
            if (pf_ack) begin
               if (trigger && !line_wrap) begin
                  // Buffer frees this cycle, so the new miss can be serviced directly
                  load_addr = 1'b1;
                  state_d   = REQ;
               end else begin
                  state_d = IDLE;
                  if (trigger) begin
                     drop_inc = 1'b1;
                  end
               end
            end else if (trigger) begin
               // A miss asking for the line already buffered is not a loss
               if (line_wrap || (next_addr != pf_addr_q)) begin
                  drop_inc = 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Prefetch address register; kept after ack, qualified by prefetch_ready
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pf_addr_q <= 32'h0;
      end else if (load_addr) begin
         pf_addr_q <= next_addr;
      end
   end

   // Line buffer; captured on the memory response
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         buf_q <= 256'h0;
      end else if (capture) begin
         buf_q <= mem_rdata;
      end
   end

   // Saturating count of completed prefetches
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         issued_q <= '0;
      end else if (issue_inc && (issued_q != {cnt_w{1'b1}})) begin
         issued_q <= issued_q + {{(cnt_w-1){1'b0}}, 1'b1};
      end
   end

   // Saturating count of triggers that were not serviced
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dropped_q <= '0;
      end else if (drop_inc && (dropped_q != {cnt_w{1'b1}})) begin
         dropped_q <= dropped_q + {{(cnt_w-1){1'b0}}, 1'b1};
      end
   end

   // Outputs come from state and registers only
   always_comb begin
      mem_read         = (state_q == REQ);
      prefetch_ready   = (state_q == FULL);
      mem_address      = pf_addr_q;
      pf_cline_address = pf_addr_q;
      prefetch_rdata   = buf_q;
      issued_count     = issued_q;
      dropped_count    = dropped_q;
   end

endmodule
